// File: rtl/sbox_keyed_init.sv
// sbox_keyed_init: fills an external single-port RAM with the identity
// permutation s[i] = i, then (with SBOX_KSA_EN defined) runs the RC4
// key-scheduling pass over it. Completion is flagged by a one-cycle done pulse.
//
// Build macro: SBOX_KSA_EN (undefined = fill only, FILL -> DONE).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   begin a pass; sampled only in IDLE
//   key        in   KEY_LEN bytes, byte 0 in the MSBs; captured on accepted start
//   mem_addr   out  RAM address
//   mem_wdata  out  RAM write data
//   mem_we     out  RAM write enable
//   mem_rdata  in   RAM read data, valid one cycle after a read address
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
module sbox_keyed_init #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned KEY_LEN = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [KEY_LEN*DATA_W-1:0]   key,
    output logic [DATA_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned DEPTH = 1 << DATA_W;

    typedef enum logic [3:0] {
        IDLE, FILL, RD_SI, LD_SI, RD_SJ, LD_SJ, WR_I, WR_J, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   i_q, i_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last_i_c;

    assign last_i_c = (i_q == DATA_W'(DEPTH - 1));

`ifdef SBOX_KSA_EN
    localparam int unsigned KEY_W  = KEY_LEN * DATA_W;
    localparam int unsigned KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    logic [DATA_W-1:0]   j_q, j_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic [DATA_W-1:0]   si_q, si_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [KEY_W-1:0]    key_sh_c;
    logic [DATA_W-1:0]   kbyte_c;

    // Key byte kidx: shift it up into the MSB byte position.
    assign key_sh_c = key_q << (32'(kidx_q) * DATA_W);
    assign kbyte_c  = key_sh_c[KEY_W-1 -: DATA_W];
`else
    logic unused_c;
    assign unused_c = ^{key, mem_rdata};
`endif

    // State and output registers; outputs are loaded with the values of the
    // state being entered so they are valid throughout that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SBOX_KSA_EN
            j_q     <= '0;
            kidx_q  <= '0;
            si_q    <= '0;
            key_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SBOX_KSA_EN
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            si_q    <= si_d;
            key_q   <= key_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SBOX_KSA_EN
        j_d     = j_q;
        kidx_d  = kidx_q;
        si_d    = si_q;
        key_d   = key_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    i_d     = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b1;
`ifdef SBOX_KSA_EN
                    j_d     = '0;
                    kidx_d  = '0;
                    key_d   = key;
`endif
                end
            end
            FILL: begin
                if (last_i_c) begin
                    i_d = '0;
`ifdef SBOX_KSA_EN
                    state_d = RD_SI;
                    addr_d  = '0;
`else
                    state_d = DONE;
`endif
                end else begin
                    i_d     = i_q + DATA_W'(1);
                    addr_d  = i_q + DATA_W'(1);
                    wdata_d = i_q + DATA_W'(1);
                    we_d    = 1'b1;
                end
            end
`ifdef SBOX_KSA_EN
            RD_SI: state_d = LD_SI;
            LD_SI: begin
                si_d    = mem_rdata;
                j_d     = j_q + mem_rdata + kbyte_c;
                addr_d  = j_q + mem_rdata + kbyte_c;
                state_d = RD_SJ;
            end
            RD_SJ: state_d = LD_SJ;
            LD_SJ: begin
                // The write-data register holds sj for the WR_I cycle.
                wdata_d = mem_rdata;
                addr_d  = i_q;
                we_d    = 1'b1;
                state_d = WR_I;
            end
            WR_I: begin
                addr_d  = j_q;
                wdata_d = si_q;
                we_d    = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                kidx_d = (kidx_q == KIDX_W'(KEY_LEN - 1)) ? '0 : kidx_q + KIDX_W'(1);
                if (last_i_c) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + DATA_W'(1);
                    addr_d  = i_q + DATA_W'(1);
                    state_d = RD_SI;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sbox_keyed_init.sv
// Bench for sbox_keyed_init (DATA_W=8, KEY_LEN=3) with a behavioural RAM,
// a software RC4 model feeding a write scoreboard, and directed runs.
module tb_sbox_keyed_init;

    localparam int unsigned DW = 8;
    localparam int unsigned KL = 3;
    localparam int unsigned N  = 256;
`ifdef SBOX_KSA_EN
    localparam bit KSA = 1'b1;
`else
    localparam bit KSA = 1'b0;
`endif
    localparam int RUN_CYC = KSA ? 7 * N + 1 : N + 1;
    localparam int RUN_WR  = KSA ? 3 * N : N;

    logic              clk;
    logic              reset;
    logic              start;
    logic [KL*DW-1:0]  key;
    logic [DW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic              done;

    sbox_keyed_init #(.DATA_W(DW), .KEY_LEN(KL)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural synchronous single-port RAM (read-before-write).
    logic [DW-1:0] ram [N];
    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cnt   = 0;
    int  done_cnt = 0;

    // Monitor: every observed write is popped from the scoreboard and compared.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write", 32'({mem_addr, mem_wdata}), 32'({e.a, e.d}));
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // Software model: identity fill followed by RC4 KSA, recording each write.
    logic [DW-1:0] ms [N];
    task automatic model_run(input logic [KL*DW-1:0] k);
        logic [DW-1:0] j, t, kb;
        for (int a = 0; a < N; a++) begin
            ms[a] = DW'(a);
            exp_q.push_back(wr_t'{a: DW'(a), d: DW'(a)});
        end
        if (KSA) begin
            j = '0;
            for (int i = 0; i < N; i++) begin
                kb = k[(KL - 1 - (i % KL)) * DW +: DW];
                j  = j + ms[i] + kb;
                exp_q.push_back(wr_t'{a: DW'(i), d: ms[j]});
                exp_q.push_back(wr_t'{a: j, d: ms[i]});
                t     = ms[i];
                ms[i] = ms[j];
                ms[j] = t;
            end
        end
    endtask

    task automatic check_ram(input string tag);
        int nbad = 0;
        for (int a = 0; a < N; a++) if (ram[a] !== ms[a]) nbad++;
        chk({tag, "_perm_mismatches"}, 32'(nbad), 32'd0);
    endtask

    // One start pulse, then wait (bounded) for done and check the whole pass.
    task automatic do_run(input logic [KL*DW-1:0] k, input string tag);
        int cyc, bl, w0;
        model_run(k);
        w0    = wr_cnt;
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = ~k;
        cyc = 1;
        bl  = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            if (busy !== 1'b1) bl++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(RUN_CYC));
        chk({tag, "_busy_low_cycles"}, 32'(bl), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_write_count"}, 32'(wr_cnt - w0), 32'(RUN_WR));
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check_ram(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, w0;
        reset = 1'b1;
        start = 1'b0;
        key   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values hold while start stays low.
        for (int c = 0; c < 4; c++) begin
            chk("reset_vals", 32'({mem_addr, mem_wdata, mem_we, busy, done}), 32'd0);
            @(negedge clk);
        end
        chk("reset_no_writes", 32'(wr_cnt), 32'd0);

        do_run(24'h000249, "run_a");
        repeat (3) @(negedge clk);
        do_run(24'hA53CF0, "run_b");

        // Reset in cycle 100 of a run, then a fresh pass.
        model_run(24'h123456);
        w0    = wr_cnt;
        key   = 24'h123456;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_writes", 32'(wr_cnt - w0), 32'd100);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        do_run(24'h010203, "run_after_rst");

        // start held high: back-to-back passes, each restarting after done.
        model_run(24'h0F0E0D);
        model_run(24'h0F0E0D);
        key   = 24'h0F0E0D;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_done1_cycle", 32'(cyc), 32'(RUN_CYC));
        @(negedge clk);
        chk("held_idle_busy", 32'(busy), 32'd0);
        chk("held_idle_done", 32'(done), 32'd0);
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_done2_cycle", 32'(cyc), 32'(RUN_CYC + 1));
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_busy_after", 32'(busy), 32'd0);
        chk("held_sb_empty", 32'(exp_q.size()), 32'd0);
        check_ram("held");
        chk("done_pulses", 32'(done_cnt), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbox_keyed_init.md
# sbox_keyed_init

Parametrised successor to the S-array fill engine: after a `start` pulse it fills an external single-port RAM with the identity permutation `s[i] = i`, then (when compiled in) runs the RC4 key-scheduling pass. The key-scheduling pass swaps entries under control of a registered key. It sits between the decryptor top-level FSM and the S-memory write/read port, and reports completion with a one-cycle `done` pulse.

## Interface
- `DATA_W`, 8: S-entry and key-byte width; `DEPTH = 2**DATA_W` (localparam); legal 2..8.
- `KEY_LEN`, 3: key length in `DATA_W`-bit bytes; ≥1.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin operation; sampled only in IDLE.
- `key` in `KEY_LEN*DATA_W`: key byte k = `key[(KEY_LEN-1-k)*DATA_W +: DATA_W]` (byte 0 in MSBs); captured on the accepted `start` edge.
- `mem_addr` out `DATA_W`: RAM address.
- `mem_wdata` out `DATA_W`: RAM write data.
- `mem_we` out 1: RAM write enable.
- `mem_rdata` in `DATA_W`: RAM read data; valid one cycle after the address is presented with `mem_we=0`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- Registers:
  - `i`, `j`: `DATA_W` bits, all arithmetic mod `DEPTH`.
  - `kidx`: wrapping 0..`KEY_LEN-1`, no divider.
  - `si`, `sj`: `DATA_W` bits.
  - `key_q`: captured key.
- States (one cycle each):
  - IDLE: `start` → FILL; clear `i`, `j`, `kidx`; capture `key`.
  - FILL: `addr=i`, `wdata=i`, `we=1`. If `i==DEPTH-1`: clear `i` → RD_SI (→ DONE without KSA). Else `i++`.
  - RD_SI: `addr=i`, `we=0`.
  - LD_SI: `si<=mem_rdata`; `j<=j+mem_rdata+key_q[kidx]`.
  - RD_SJ: `addr=j` (new value), `we=0`.
  - LD_SJ: `sj<=mem_rdata`.
  - WR_I: `addr=i`, `wdata=sj`, `we=1`.
  - WR_J: `addr=j`, `wdata=si`, `we=1`; `kidx` wraps at `KEY_LEN-1`. If `i==DEPTH-1` → DONE, else `i++` → RD_SI.
  - DONE: `done=1` → IDLE.
- Outputs in states where they are not listed above: `addr` holds its last value and `we=0`.
- Case `i==j`: WR_I then WR_J both write the original `s[i]`, so the entry is unchanged. No special case is needed.
- `start` while busy is ignored. A `key` change while busy has no effect.
- After DONE, the next `start` begins a fresh pass: FILL always precedes KSA.

## Timing
- Reset values: state IDLE, `mem_addr=0`, `mem_wdata=0`, `mem_we=0`, `busy=0`, `done=0`, internal registers 0.
- Reset mid-operation returns to IDLE on that edge with `we=0`. RAM contents are then undefined.
- FILL takes `DEPTH` cycles; each KSA iteration takes 6 cycles.
- Let edge E0 be the clock edge that samples `start`.
  - `done` is high in cycle `7*DEPTH+1` after E0 with KSA (cycle `DEPTH+1` without).
  - `busy` is high from cycle 1 through the `done` cycle inclusive.
- The earliest `start` accepted is in the cycle after `done`.

## Configuration
- `SBOX_KSA_EN` defined: KSA states, `key_q`, `j`, `kidx`, `si`, `sj` are present and the block behaves as above.
- `SBOX_KSA_EN` not defined: FILL → DONE directly. The `key` and `mem_rdata` ports remain but are ignored, and `done` arrives at cycle `DEPTH+1`.

## Test plan
- Fill only, `DATA_W=8`, `SBOX_KSA_EN` undefined, `start` one cycle:
  - 256 writes with `addr=wdata=0..255` on consecutive cycles.
  - `done` pulse at cycle 257, then `busy=0`.
- KSA, `DATA_W=2`, `KEY_LEN=1`, `key=0`, behavioural RAM:
  - final RAM is `{0,2,3,1}`.
  - `done` at cycle 29 after E0.
- KSA, `DATA_W=8`, `KEY_LEN=3`, `key=24'h000249`:
  - final RAM matches a software RC4 KSA.
  - exactly 256+512 writes are observed.
- Reset asserted in cycle 100 of a KSA run, then a fresh `start`:
  - `we=0` and `busy=0` the cycle after reset.
  - the second run completes with the correct permutation.
- `start` held high throughout:
  - each run restarts only after the `done` cycle.
  - no `done` pulses appear other than those at run completion.
- Reset values: outputs match the reset list and stay there while `start=0`.
